// File: rtl/subtractor_8_bit_serial_with_overflow_if.sv
// subtractor_8_bit_serial_with_overflow_if: start/operand/result bundle for the serial subtractor
interface subtractor_8_bit_serial_with_overflow_if;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] diff;
    logic       b_out;
    logic       overflow;
    logic       busy;
    logic       done;
    modport master (
        output start, a, b,
        input  diff, b_out, overflow, busy, done
    );
    modport slave (
        input  start, a, b,
        output diff, b_out, overflow, busy, done
    );
endinterface

// File: rtl/subtractor_8_bit_serial_with_overflow.sv
// subtractor_8_bit_serial_with_overflow: bit-serial 8-bit a-b with borrow and signed-overflow flags
module subtractor_8_bit_serial_with_overflow (
    input logic clk,
    input logic reset,
    subtractor_8_bit_serial_with_overflow_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t     state, state_n;
    logic [7:0] a_sr, a_sr_n, b_sr, b_sr_n, raw, raw_n, diff_q, diff_n;
    logic [2:0] cnt, cnt_n;
    logic       br, br_n, bo_q, bo_n, ov_q, ov_n, d_bit;
    // state, shift registers and result registers; reset wins over everything
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            a_sr   <= '0;
            b_sr   <= '0;
            raw    <= '0;
            cnt    <= '0;
            br     <= 1'b0;
            diff_q <= '0;
            bo_q   <= 1'b0;
            ov_q   <= 1'b0;
        end else begin
            state  <= state_n;
            a_sr   <= a_sr_n;
            b_sr   <= b_sr_n;
            raw    <= raw_n;
            cnt    <= cnt_n;
            br     <= br_n;
            diff_q <= diff_n;
            bo_q   <= bo_n;
            ov_q   <= ov_n;
        end
    end
    // next state and one LSB-first full-subtractor step per RUN cycle; results load on bit 7
    always_comb begin
        state_n = state;
        a_sr_n  = a_sr;
        b_sr_n  = b_sr;
        raw_n   = raw;
        cnt_n   = cnt;
        br_n    = br;
        diff_n  = diff_q;
        bo_n    = bo_q;
        ov_n    = ov_q;
        d_bit   = a_sr[0] ^ b_sr[0] ^ br;
        unique case (state)
            IDLE: if (bus.start) begin
                a_sr_n  = bus.a;
                b_sr_n  = bus.b;
                raw_n   = '0;
                cnt_n   = '0;
                br_n    = 1'b0;
                state_n = RUN;
            end
            RUN: begin
                a_sr_n = {1'b0, a_sr[7:1]};
                b_sr_n = {1'b0, b_sr[7:1]};
                br_n   = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & br);
                raw_n  = {d_bit, raw[7:1]};
                cnt_n  = cnt + 3'd1;
                if (cnt == 3'd7) begin
                    state_n = DONE;
                    ov_n    = (a_sr[0] != b_sr[0]) & (d_bit != a_sr[0]);
                    bo_n    = br_n;
                    diff_n  = ov_n ? 8'h00 : raw_n;
                end
            end
            DONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end
    assign bus.diff     = diff_q;
    assign bus.b_out    = bo_q;
    assign bus.overflow = ov_q;
    assign bus.busy     = state != IDLE;
    assign bus.done     = state == DONE;
endmodule

// File: doc/subtractor_8_bit_serial_with_overflow.md
SUBTRACTOR_8_BIT_SERIAL_WITH_OVERFLOW -- requirements
Module: subtractor_8_bit_serial_with_overflow

Interface
REQ-001 Parameters: none; operand width SHALL be fixed at 8 bits.
REQ-002 clk  input  1  sole clock; all state SHALL update on the rising edge of clk.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 start  input  1  request to begin a subtraction; accepted only in IDLE.
REQ-005 a  input  8  minuend, two's complement; sampled on the accepting edge only.
REQ-006 b  input  8  subtrahend, two's complement; sampled on the accepting edge only.
REQ-007 diff  output  8  registered result a-b, forced to 8'h00 when overflow=1.
REQ-008 b_out  output  1  registered final borrow (1 when a < b unsigned).
REQ-009 overflow  output  1  registered signed-overflow flag for a-b.
REQ-010 busy  output  1  high whenever the state is not IDLE.
REQ-011 done  output  1  single-cycle pulse marking valid diff/b_out/overflow.

Function
REQ-012 The FSM SHALL have three states: IDLE, RUN, DONE.
REQ-013 IDLE: start=1 on an edge SHALL latch a and b into internal shift registers, clear the internal borrow, load bit counter with 0 and enter RUN.
REQ-014 RUN: each edge SHALL process one bit, LSB first: d_i = a_i ^ b_i ^ br; br_next = (~a_i & b_i) | (~(a_i ^ b_i) & br); d_i shifted into the raw-result register.
REQ-015 RUN: the counter SHALL increment per edge; on the edge processing bit 7 the FSM SHALL enter DONE.
REQ-016 On that same edge diff, b_out and overflow SHALL be loaded: overflow = (a[7] != b[7]) & (raw[7] != a[7]); b_out = final borrow; diff = overflow ? 8'h00 : raw.
REQ-017 DONE: done SHALL be 1 for exactly this one cycle; next edge SHALL return to IDLE unconditionally.
REQ-018 Latency: with start sampled on edge E0, done SHALL be high between edge E8 and edge E9; busy SHALL be high from E0 through E9.
REQ-019 start while in RUN or DONE SHALL be ignored; operands are not re-sampled and no extra done pulse occurs.
REQ-020 diff, b_out and overflow SHALL hold their values from the last DONE until the next DONE load or reset; they SHALL NOT change during RUN.
REQ-021 Changes on a or b after the accepting edge SHALL NOT affect the result in flight.
REQ-022 start asserted in the first IDLE cycle after DONE SHALL be accepted, giving back-to-back operations spaced 10 edges apart.

Reset
REQ-023 reset=1 on an edge SHALL force IDLE and clear diff, b_out, overflow, busy, done, counter, borrow and shift registers to 0.
REQ-024 reset SHALL take priority over start and over any in-flight operation; an aborted operation SHALL produce no done pulse.
REQ-025 start sampled together with reset SHALL be ignored.

Verification
REQ-026 a=8'h05, b=8'h03, start at E0 -> done at E8; diff=8'h02, b_out=0, overflow=0.
REQ-027 a=8'h03, b=8'h05 -> diff=8'hFE, b_out=1, overflow=0.
REQ-028 a=8'h80, b=8'h01 (-128-1) -> raw 8'h7F, overflow=1, diff=8'h00, b_out=0.
REQ-029 a=8'h7F, b=8'hFF (127-(-1)) -> raw 8'h80, overflow=1, diff=8'h00, b_out=1.
REQ-030 Start 8'h10-8'h01; at E3 pulse start with 8'h00/8'h01 and change a/b -> start ignored; single done at E8; diff=8'h0F.
REQ-031 Start an operation, assert reset at E4 -> next cycle busy=0, done=0, all outputs 0; no done follows; a new start then completes normally 8 edges later.
